// File: rtl/sdm_pkg.sv
// Shared fixed-point helpers and types for the sigma-delta (SDM) datapath.
// fx_frac_bits : number of fraction bits for a given total/integer width.
// fx_one       : the +1.0 constant (1 << F).
// fx_neg_one   : the -1.0 constant.
// dec_state_t  : decoder fill state.
package sdm_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } dec_state_t;

    function automatic int fx_frac_bits(input int bit_width, input int int_width);
        return bit_width - int_width - 1;
    endfunction

    function automatic int fx_one(input int bit_width, input int int_width);
        return 1 << fx_frac_bits(bit_width, int_width);
    endfunction

    function automatic int fx_neg_one(input int bit_width, input int int_width);
        return -fx_one(bit_width, int_width);
    endfunction

endpackage

// File: rtl/sdm_decoder_if.sv
// Bitstream-in / word-out bundle of the SDM decoder.
// clear, in_valid, in_bit : driven by the bitstream source (master).
// out, out_valid, full    : driven by the decoder (slave).
interface sdm_decoder_if #(
    parameter int unsigned BIT_WIDTH = 16
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_bit;
    logic [BIT_WIDTH-1:0] out;
    logic                 out_valid;
    logic                 full;

    modport master (
        output clear, in_valid, in_bit,
        input  out, out_valid, full
    );

    modport slave (
        input  clear, in_valid, in_bit,
        output out, out_valid, full
    );
endinterface

// File: rtl/sdm_bit_window.sv
// N-bit circular delay line (N = 2^WIN_LOG2) holding the most recent accepted bits.
// CLK, nRST : clock, asynchronous active-low reset.
// clear     : rewinds the write pointer; contents are left as-is.
// push      : write din at the pointer and advance it.
// din       : incoming bit.
// oldest    : bit at the write pointer, i.e. the one about to be overwritten.
module sdm_bit_window #(
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic push,
    input  logic din,
    output logic oldest
);
    localparam int unsigned N = 1 << WIN_LOG2;

    logic [N-1:0]        line_q;
    logic [WIN_LOG2-1:0] wr_ptr_q;

    assign oldest = line_q[wr_ptr_q];

    // Pointer width equals log2(N), so the increment wraps N-1 -> 0 for free.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            line_q   <= '0;
            wr_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
        end else if (push) begin
            line_q[wr_ptr_q] <= din;
            wr_ptr_q         <= wr_ptr_q + WIN_LOG2'(1);
        end
    end
endmodule

// File: rtl/sdm_decoder.sv
// Sigma-delta bitstream decoder: moving average of the last N = 2^WIN_LOG2 accepted bits,
// bit 1 = +1.0, bit 0 = -1.0, scaled to a signed BIT_WIDTH fixed-point word.
// CLK, nRST : clock, asynchronous active-low reset.
// bus       : sdm_decoder_if slave (clear, in_valid, in_bit in; out, out_valid, full out).
module sdm_decoder
    import sdm_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned INT_WIDTH = 1,
    parameter int unsigned WIN_LOG2  = 4
) (
    input logic          CLK,
    input logic          nRST,
    sdm_decoder_if.slave bus
);
    localparam int FRAC  = fx_frac_bits(BIT_WIDTH, INT_WIDTH);
    localparam int N_WIN = 1 << WIN_LOG2;
    localparam int CW    = WIN_LOG2 + 1;  // count width, holds 0..N
    localparam int OW    = WIN_LOG2 + 2;  // signed width of 2*ones - N
    localparam int SHIFT = FRAC - WIN_LOG2;

    if (WIN_LOG2 < 1 || int'(WIN_LOG2) > FRAC || INT_WIDTH < 1) begin : g_param_check
        $error("sdm_decoder: requires 1 <= WIN_LOG2 <= F and INT_WIDTH >= 1");
    end

    dec_state_t           state_q;
    logic [CW-1:0]        ones_q;
    logic [CW-1:0]        fill_cnt_q;
    logic                 full_q;
    logic                 out_valid_q;
    logic [BIT_WIDTH-1:0] out_q;

    logic                        accept;
    logic                        oldest;
    logic [CW-1:0]               ones_d;
    logic [OW-1:0]               diff;
    logic signed [BIT_WIDTH-1:0] diff_ext;
    logic signed [BIT_WIDTH-1:0] scaled;

    assign accept = bus.in_valid & ~bus.clear;

    sdm_bit_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (bus.clear),
        .push   (accept),
        .din    (bus.in_bit),
        .oldest (oldest)
    );

    // Updated count including the current sample; once full, the bit leaving the window
    // is subtracted.
    always_comb begin
        ones_d = ones_q + CW'(bus.in_bit);
        if (state_q == FULL) begin
            ones_d = ones_d - CW'(oldest);
        end
    end

    // 2*ones - N computed modulo 2^OW: the true result lies in [-N, N], which fits OW
    // bits signed even though the intermediate 2*ones may not.
    always_comb begin
        diff     = {ones_d, 1'b0} - OW'(N_WIN);
        diff_ext = BIT_WIDTH'($signed(diff));
        scaled   = diff_ext <<< SHIFT;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= EMPTY;
            ones_q      <= '0;
            fill_cnt_q  <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.clear) begin
            // Clear wins over a coincident sample; out keeps its last value.
            state_q     <= EMPTY;
            ones_q      <= '0;
            fill_cnt_q  <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            ones_q <= ones_d;
            unique case (state_q)
                EMPTY: begin
                    state_q     <= FILL;
                    fill_cnt_q  <= CW'(1);
                    out_valid_q <= 1'b0;
                end
                FILL: begin
                    fill_cnt_q <= fill_cnt_q + CW'(1);
                    if (fill_cnt_q + CW'(1) == CW'(N_WIN)) begin
                        state_q     <= FULL;
                        full_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_q       <= scaled;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    out_valid_q <= 1'b1;
                    out_q       <= scaled;
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.full      = full_q;
endmodule

// File: tb/tb_sdm_decoder.sv
// Self-checking bench for sdm_decoder (BIT_WIDTH=16, INT_WIDTH=1, WIN_LOG2=4).
// The reference keeps the accepted bits in a queue trimmed to the last N and recomputes
// the average from scratch on every accepted bit.
module tb_sdm_decoder;
    localparam int BW = 16;
    localparam int IW = 1;
    localparam int WL = 4;
    localparam int N  = 16;
    localparam int F  = 14;
    localparam int SH = F - WL;

    logic clk;
    logic nrst;

    sdm_decoder_if #(.BIT_WIDTH(BW)) bus ();

    sdm_decoder #(
        .BIT_WIDTH (BW),
        .INT_WIDTH (IW),
        .WIN_LOG2  (WL)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit          win[$];
    logic [15:0] exp_out   = 16'h0000;
    logic        exp_valid = 1'b0;
    logic        exp_full  = 1'b0;

    // Drive one cycle of inputs, then advance the reference model to match the edge.
    task automatic drive(input logic c, input logic v, input logic b);
        int ones;
        @(negedge clk);
        bus.clear    = c;
        bus.in_valid = v;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        if (c) begin
            win.delete();
            exp_valid = 1'b0;
        end else if (v) begin
            win.push_back(b);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                ones = 0;
                foreach (win[k]) ones += int'(win[k]);
                exp_out   = 16'((2 * ones - N) * (1 << SH));
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
        end else begin
            exp_valid = 1'b0;
        end
        exp_full = (win.size() == N);
    endtask

    task automatic model_reset();
        win.delete();
        exp_out   = 16'h0000;
        exp_valid = 1'b0;
        exp_full  = 1'b0;
    endtask

    task automatic test_reset();
        nrst         = 1'b0;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.full !== 1'b0) begin
            n_err++;
            $display("FAIL reset: out=%h valid=%b full=%b, required out=0000 valid=0 full=0",
                     bus.out, bus.out_valid, bus.full);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_fill_ones_zeros();
        logic [15:0] step_exp;
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                n_err++;
                $display("FAIL fill_ones[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                         i, bus.out, bus.out_valid, bus.full, exp_out, exp_valid, exp_full);
            end
        end
        n_vec++;
        if (bus.out !== 16'h4000 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL plus_one: out=%h valid=%b, required 4000 1", bus.out, bus.out_valid);
        end
        step_exp = 16'h4000;
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            step_exp = step_exp - 16'h0800;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out !== step_exp || bus.out !== exp_out) begin
                n_err++;
                $display("FAIL step_down[%0d]: out=%h valid=%b, required %h 1",
                         i, bus.out, bus.out_valid, step_exp);
            end
        end
        n_vec++;
        if (bus.out !== 16'hC000) begin
            n_err++;
            $display("FAIL minus_one: out=%h, required c000", bus.out);
        end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 2 * N; i++) begin
            drive(1'b0, 1'b1, logic'(i % 2 == 0));
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                n_err++;
                $display("FAIL alternating[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                         i, bus.out, bus.out_valid, bus.full, exp_out, exp_valid, exp_full);
            end
            if (i >= N) begin
                n_vec++;
                if (bus.out !== 16'h0000 && bus.out !== 16'h0800) begin
                    n_err++;
                    $display("FAIL alt_range[%0d]: out=%h, required 0000 or 0800", i, bus.out);
                end
            end
        end
    endtask

    // Pattern 1,1,1,0 once without gaps and once with random gaps; valid-cycle outputs
    // must form the same sequence.
    task automatic test_pattern_gaps();
        logic [15:0] seq_a[$];
        logic [15:0] seq_b[$];
        for (int pass = 0; pass < 2; pass++) begin
            int p;
            drive(1'b1, 1'b0, 1'b0);
            p = 0;
            while (p < 3 * N) begin
                logic v;
                v = (pass == 0) ? 1'b1 : logic'($urandom_range(0, 2) != 0);
                drive(1'b0, v, logic'(p % 4 != 3));
                if (v) p++;
                n_vec++;
                if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                    n_err++;
                    $display("FAIL pattern%0d[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                             pass, p, bus.out, bus.out_valid, bus.full, exp_out, exp_valid,
                             exp_full);
                end
                if (bus.out_valid === 1'b1) begin
                    n_vec++;
                    if (bus.out !== 16'h2000) begin
                        n_err++;
                        $display("FAIL pattern_half: out=%h, required 2000", bus.out);
                    end
                    if (pass == 0) seq_a.push_back(bus.out);
                    else           seq_b.push_back(bus.out);
                end
            end
        end
        n_vec++;
        if (seq_a.size() != seq_b.size() || seq_a.size() != 2 * N + 1) begin
            n_err++;
            $display("FAIL pattern_seq: counts %0d / %0d, required %0d each",
                     seq_a.size(), seq_b.size(), 2 * N + 1);
        end
    endtask

    // First-order SDM encoder model fed with -0.5, looped into the decoder.
    task automatic test_loopback();
        int acc;
        int x;
        int d;
        logic b;
        acc = 0;
        x   = -(1 << (F - 1));
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4 * N; i++) begin
            b   = logic'(acc >= 0);
            acc = acc + x - (b ? (1 << F) : -(1 << F));
            drive(1'b0, 1'b1, b);
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out) begin
                n_err++;
                $display("FAIL loopback[%0d]: out=%h valid=%b, required %h %b",
                         i, bus.out, bus.out_valid, exp_out, exp_valid);
            end
            if (i >= 2 * N) begin
                d = int'($signed(bus.out)) + (1 << (F - 1));
                n_vec++;
                if (d > 16'h0800 || d < -16'sh0800 || bus.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL loopback_tol[%0d]: out=%h, required e000 +/- 0800", i, bus.out);
                end
            end
        end
    endtask

    task automatic test_clear();
        int first_valid;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, logic'($urandom_range(0, 1)));
        drive(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (bus.full !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear_win: full=%b valid=%b, required 0 0", bus.full, bus.out_valid);
        end
        first_valid = -1;
        for (int i = 1; i <= N; i++) begin
            drive(1'b0, 1'b1, logic'($urandom_range(0, 1)));
            if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = i;
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                n_err++;
                $display("FAIL clear_refill[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                         i, bus.out, bus.out_valid, bus.full, exp_out, exp_valid, exp_full);
            end
        end
        n_vec++;
        if (first_valid != N) begin
            n_err++;
            $display("FAIL clear_latency: first valid after %0d bits, required %0d",
                     first_valid, N);
        end
    endtask

    task automatic test_async_reset();
        int first_valid;
        for (int i = 0; i < N + 4; i++) drive(1'b0, 1'b1, logic'($urandom_range(0, 1)));
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.full !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: out=%h valid=%b full=%b, required 0000 0 0",
                     bus.out, bus.out_valid, bus.full);
        end
        @(negedge clk);
        nrst = 1'b1;
        first_valid = -1;
        for (int i = 1; i <= N; i++) begin
            drive(1'b0, 1'b1, logic'($urandom_range(0, 1)));
            if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = i;
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                n_err++;
                $display("FAIL reset_refill[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                         i, bus.out, bus.out_valid, bus.full, exp_out, exp_valid, exp_full);
            end
        end
        n_vec++;
        if (first_valid != N) begin
            n_err++;
            $display("FAIL reset_latency: first valid after %0d bits, required %0d",
                     first_valid, N);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)));
            n_vec++;
            if (bus.out_valid !== exp_valid || bus.out !== exp_out || bus.full !== exp_full) begin
                n_err++;
                $display("FAIL random[%0d]: out=%h valid=%b full=%b, required %h %b %b",
                         i, bus.out, bus.out_valid, bus.full, exp_out, exp_valid, exp_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_ones_zeros();
        test_alternating();
        test_pattern_gaps();
        test_loopback();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
